// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, credit-limited in-order memory requests,
// and a small {word, pc} buffer handed to decode under valid/ready, flushed by redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   word_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   target;
  logic          req_fire;
  logic          keep_resp;
  logic          drop_resp;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Every accepted request owns a buffer slot until it is popped or discarded.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = rst_n && (credit_used < DEPTH_W) && !redirect_valid;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign target         = redirect_pc & 32'hFFFF_FFFC;

  assign keep_resp = imem_resp_valid && !redirect_valid && (discard_q == '0);
  assign drop_resp = imem_resp_valid && !redirect_valid && (discard_q != '0);
  assign pop       = instr_valid && instr_ready && !redirect_valid;

  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instruction = word_mem[rd_ptr_q];
  assign instr_pc    = pc_mem[rd_ptr_q];

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      // Everything still outstanding belongs to the old path, except a response landing right now.
      pc_d       = target;
      resp_pc_d  = target;
      inflight_d = inflight_q - CW'(imem_resp_valid);
      discard_d  = inflight_q - CW'(imem_resp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
      if (drop_resp) begin
        discard_d = discard_q - CW'(1);
      end
      if (keep_resp) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CW'(keep_resp) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is reset so the head presents the defined reset word and PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_mem[i] <= '0;
        pc_mem[i]   <= RESET_PC;
      end
    end else if (keep_resp) begin
      word_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch, stall, redirect, reset and PC-wrap
// scenarios against a latency-configurable in-order instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  logic        w_rst_n;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instruction;
  logic [31:0] w_instr_pc;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;
  int budget   = 0;
  int w_budget = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  int          del_cyc[$];
  logic [63:0] sb[$];

  logic        w_hs;
  logic [31:0] w_hs_addr;
  logic [31:0] w_acc[$];
  logic [63:0] w_sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
    .instruction(w_instruction), .instr_pc(w_instr_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0031_00B3;
      32'h0000_0004: return 32'h4062_8233;
      32'h0000_0008: return 32'h00A1_8093;
      default:       return {~a[15:0], a[15:0]};
    endcase
  endfunction

  // Main memory: answers accepted requests in order after 'lat' cycles; forgets everything in reset.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_req_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
        imem_resp_valid = 1'b0;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEAD_BEEF;
      end
      #1;
      imem_req_ready = (budget > 0);
    end
  end

  // Request handshakes are sampled mid-cycle, when the combinational request has settled.
  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      acc_addr.push_back(imem_addr);
      acc_cyc.push_back(cyc);
      budget--;
    end
  end

  // Monitor: every word the decoder actually takes must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_instr: got pc=%h word=%h, expected no delivery", instr_pc, instruction);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        if ({instr_pc, instruction} !== exp)
          begin
            failures++;
            $display("[TB] FAIL deliver: got pc=%h word=%h, expected pc=%h word=%h",
                     instr_pc, instruction, exp[63:32], exp[31:0]);
          end
      end
      del_cyc.push_back(cyc);
    end
  end

  // Wrap-test memory: fixed 1-cycle latency, request budget limited.
  initial begin
    w_resp_valid = 1'b0;
    w_resp_data  = 32'h0;
    w_req_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      w_resp_valid = w_rst_n && w_hs;
      w_resp_data  = w_hs ? mem_word(w_hs_addr) : 32'hDEAD_BEEF;
      #1;
      w_req_ready = (w_budget > 0);
    end
  end

  always @(negedge clk) begin
    w_hs      = w_rst_n && w_req_valid && w_req_ready;
    w_hs_addr = w_addr;
    if (w_hs) begin
      w_acc.push_back(w_addr);
      w_budget--;
    end
    if (w_rst_n && w_instr_valid && w_instr_ready) begin
      checks++;
      if (w_sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL wrap_unexpected: got pc=%h word=%h, expected no delivery", w_instr_pc, w_instruction);
      end else begin
        logic [63:0] exp;
        exp = w_sb.pop_front();
        if ({w_instr_pc, w_instruction} !== exp) begin
          failures++;
          $display("[TB] FAIL wrap_deliver: got pc=%h word=%h, expected pc=%h word=%h",
                   w_instr_pc, w_instruction, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input int new_budget, input int new_lat);
    instr_ready = rdy;
    budget      = new_budget;
    lat         = new_lat;
  endtask

  task automatic expectInstr(input logic [31:0] pc);
    sb.push_back({pc, mem_word(pc)});
  endtask

  task automatic waitDrain(input string name, input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s: got %0d words still pending, expected 0 after %0d cycles", name, sb.size(), max_cycles);
      sb.delete();
    end
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    budget         = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    acc_addr.delete();
    acc_cyc.delete();
    del_cyc.delete();
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    instr_ready      = 1'b0;
    w_rst_n          = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'h0;
    w_instr_ready    = 1'b1;
    w_hs             = 1'b0;
    w_hs_addr        = 32'h0;

    // Reset values on both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0000_0000);
    checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_instruction", instruction, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0000_0000);
    checkOutput("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
    checkOutput("wrap_rst_instr_pc", w_instr_pc, 32'hFFFF_FFF8);
    checkOutput("wrap_rst_req_valid", {31'b0, w_req_valid}, 32'd0);

    // Basic in-order fetch with 1-cycle memory
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 3, 1);
    expectInstr(32'h0);
    expectInstr(32'h4);
    expectInstr(32'h8);
    rst_n = 1'b1;
    waitDrain("t1_drain", 30);
    checkOutput("t1_req_count", 32'(acc_addr.size()), 32'd3);
    if (acc_addr.size() == 3) begin
      checkOutput("t1_addr0", acc_addr[0], 32'h0);
      checkOutput("t1_addr1", acc_addr[1], 32'h4);
      checkOutput("t1_addr2", acc_addr[2], 32'h8);
    end
    if (acc_cyc.size() > 0 && del_cyc.size() > 0)
      checkOutput("t1_first_latency", 32'(del_cyc[0] - acc_cyc[0]), 32'd2);

    // Decoder stall: credits cap outstanding work at DEPTH, head stays put
    resetDut();
    applyStimulus(1'b0, 5, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t2_valid_early", {31'b0, instr_valid}, 32'd1);
    checkOutput("t2_head_early", instruction, 32'h0031_00B3);
    repeat (6) @(negedge clk);
    checkOutput("t2_req_count", 32'(acc_addr.size()), 32'd2);
    checkOutput("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t2_head_late", instruction, 32'h0031_00B3);
    checkOutput("t2_head_pc", instr_pc, 32'h0);
    @(posedge clk);
    #1;
    expectInstr(32'h0);
    expectInstr(32'h4);
    expectInstr(32'h8);
    expectInstr(32'hC);
    expectInstr(32'h10);
    instr_ready = 1'b1;
    waitDrain("t2_drain", 40);
    if (acc_addr.size() >= 3)
      checkOutput("t2_resume_addr", acc_addr[2], 32'h8);

    // Redirect with two stale requests in flight on 3-cycle memory
    resetDut();
    applyStimulus(1'b1, 2, 3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    budget         = 2;
    expectInstr(32'h100);
    expectInstr(32'h104);
    @(negedge clk);
    checkOutput("t3_inflight", 32'(acc_addr.size()), 32'd2);
    checkOutput("t3_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    checkOutput("t3_new_addr", imem_addr, 32'h0000_0100);
    waitDrain("t3_drain", 40);
    if (acc_addr.size() >= 3)
      checkOutput("t3_first_new_req", acc_addr[2], 32'h100);

    // Redirect in the same cycle as a response and a pop
    resetDut();
    applyStimulus(1'b1, 2, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0201;
    budget         = 1;
    @(negedge clk);
    checkOutput("t4_valid_at_redirect", {31'b0, instr_valid}, 32'd1);
    checkOutput("t4_head_at_redirect", instruction, 32'h0031_00B3);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    expectInstr(32'h200);
    @(negedge clk);
    checkOutput("t4_flushed_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t4_req_addr", imem_addr, 32'h0000_0200);
    waitDrain("t4_drain", 20);

    // Asynchronous reset with one word buffered and one request in flight
    @(posedge clk);
    #1;
    acc_addr.delete();
    applyStimulus(1'b0, 2, 2);
    begin
      int n = 0;
      while (acc_addr.size() < 2 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    checkOutput("t5_two_requests", 32'(acc_addr.size()), 32'd2);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("t5_buffered", {31'b0, instr_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t5_rst_addr", imem_addr, 32'h0);
    checkOutput("t5_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("t5_rst_instruction", instruction, 32'h0);
    checkOutput("t5_rst_instr_pc", instr_pc, 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    acc_addr.delete();
    sb.delete();
    applyStimulus(1'b1, 2, 1);
    expectInstr(32'h0);
    expectInstr(32'h4);
    rst_n = 1'b1;
    waitDrain("t5_drain", 30);
    if (acc_addr.size() > 0)
      checkOutput("t5_first_req", acc_addr[0], 32'h0);
    repeat (5) @(negedge clk);

    // PC wrap from a high reset address on the second instance
    @(posedge clk);
    #1;
    w_budget = 3;
    w_sb.push_back({32'hFFFF_FFF8, mem_word(32'hFFFF_FFF8)});
    w_sb.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    w_sb.push_back({32'h0000_0000, mem_word(32'h0000_0000)});
    w_rst_n = 1'b1;
    begin
      int n = 0;
      while (w_sb.size() != 0 && n < 30) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    checkOutput("wrap_pending", 32'(w_sb.size()), 32'd0);
    checkOutput("wrap_req_count", 32'(w_acc.size()), 32'd3);
    if (w_acc.size() == 3) begin
      checkOutput("wrap_addr0", w_acc[0], 32'hFFFF_FFF8);
      checkOutput("wrap_addr1", w_acc[1], 32'hFFFF_FFFC);
      checkOutput("wrap_addr2", w_acc[2], 32'h0000_0000);
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
